// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared state encoding and defaults for the SRAM / memory-mapped I/O controller
package mem_io_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - parametrised-width two-flop synchronizer with asynchronous clear
module io_sync #(
   parameter int W = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - single-word SRAM controller with wait states and one memory-mapped I/O address
module mem_io_ctrl
   import mem_io_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter int                WAIT_STATES = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(DEFAULT_IO_ADDR),
   parameter int                SW_W        = 10,
   parameter int                NUM_HEX     = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 req,
   input  logic                 we_req,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata,
   output logic                 done,
   output logic                 busy,
   output logic [ADDR_W-1:0]    sram_addr,
   output logic [DATA_W-1:0]    sram_wdata,
   input  logic [DATA_W-1:0]    sram_rdata,
   output logic                 sram_oe_n,
   output logic                 sram_we_n,
   input  logic [SW_W-1:0]      sw,
   output logic [NUM_HEX*4-1:0] hex_out
);

   localparam int HEX_W = NUM_HEX * 4;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [SW_W-1:0]  sw_sync;

   io_sync #(.W(SW_W)) u_sw_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .d     (sw),
      .q     (sw_sync)
   );

   assign done = (state == DONE);
   assign busy = (state != IDLE);

   // Strobes only change on the accept and final ACCESS edges, so address/data are
   // already stable when a strobe falls and stay put until after it rises.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rdata      <= '0;
         hex_out    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (addr == IO_ADDR) begin
                     if (we_req) hex_out <= wdata[HEX_W-1:0];
                     else        rdata   <= DATA_W'(sw_sync);
                     state <= DONE;
                  end else begin
                     sram_addr  <= addr;
                     sram_wdata <= wdata;
                     cnt        <= CNT_W'(WAIT_STATES);
                     sram_we_n  <= ~we_req;
                     sram_oe_n  <= we_req;
                     state      <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  // An asserted output enable identifies the access as a read.
                  if (!sram_oe_n) rdata <= sram_rdata;
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - self-checking bench for mem_io_ctrl with SRAM and I/O reference model
module tb_mem_io_ctrl;

   localparam int WS_A = 2;
   localparam int WS_B = 0;
   localparam logic [15:0] IO_A = 16'hFFFF;

   logic Clk;
   logic Reset;

   logic        req_a, we_req_a;
   logic [15:0] addr_a, wdata_a, rdata_a, sram_addr_a, sram_wdata_a, sram_rdata_a;
   logic        done_a, busy_a, sram_oe_n_a, sram_we_n_a;
   logic [9:0]  sw_a;
   logic [15:0] hex_out_a;

   logic        req_b, we_req_b;
   logic [15:0] addr_b, wdata_b, rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;
   logic        done_b, busy_b, sram_oe_n_b, sram_we_n_b;
   logic [9:0]  sw_b;
   logic [15:0] hex_out_b;

   int total = 0;
   int bad   = 0;

   mem_io_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS_A), .IO_ADDR(IO_A),
                 .SW_W(10), .NUM_HEX(4)) dut_a (
      .Clk(Clk), .Reset(Reset), .req(req_a), .we_req(we_req_a), .addr(addr_a),
      .wdata(wdata_a), .rdata(rdata_a), .done(done_a), .busy(busy_a),
      .sram_addr(sram_addr_a), .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata_a),
      .sram_oe_n(sram_oe_n_a), .sram_we_n(sram_we_n_a), .sw(sw_a), .hex_out(hex_out_a)
   );

   mem_io_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS_B), .IO_ADDR(IO_A),
                 .SW_W(10), .NUM_HEX(4)) dut_b (
      .Clk(Clk), .Reset(Reset), .req(req_b), .we_req(we_req_b), .addr(addr_b),
      .wdata(wdata_b), .rdata(rdata_b), .done(done_b), .busy(busy_b),
      .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b),
      .sram_oe_n(sram_oe_n_b), .sram_we_n(sram_we_n_b), .sw(sw_b), .hex_out(hex_out_b)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Bench-side SRAM devices: A is a real 256-word memory, B returns the inverted address.
   logic [15:0] mem_a [0:255];
   always @(posedge Clk) if (!sram_we_n_a) mem_a[sram_addr_a[7:0]] <= sram_wdata_a;
   assign sram_rdata_a = sram_oe_n_a ? 16'h0000 : mem_a[sram_addr_a[7:0]];
   assign sram_rdata_b = sram_oe_n_b ? 16'h0000 : ~sram_addr_b;

   // Reference state: what the controller should hold, tracked per transaction.
   logic [15:0] ref_mem [0:255];
   int          pool[$];
   logic [15:0] ref_rdata;
   logic [15:0] ref_hex;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic access_a(input logic w, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output int oe_lo, output int we_lo,
                           output int hold_err, output logic [15:0] rd);
      lat = 0; oe_lo = 0; we_lo = 0; hold_err = 0; rd = 16'hDEAD;
      @(negedge Clk);
      req_a = 1'b1; we_req_a = w; addr_a = a; wdata_a = d;
      for (int n = 1; n <= 20; n++) begin
         @(negedge Clk);
         req_a = 1'b0; addr_a = ~a; wdata_a = ~d;
         if (!sram_oe_n_a) oe_lo++;
         if (!sram_we_n_a) we_lo++;
         if ((!sram_oe_n_a || !sram_we_n_a) && (sram_addr_a !== a || sram_wdata_a !== d))
            hold_err++;
         if (done_a) begin
            lat = n;
            rd  = rdata_a;
            break;
         end
      end
   endtask

   int          lat, oe_lo, we_lo, hold_err;
   logic [15:0] rd, a, d;
   int          kind;
   int          n_done, n_acc, last_done, gap_err, exp_acc;

   initial begin
      Reset = 1'b1;
      req_a = 0; we_req_a = 0; addr_a = 0; wdata_a = 0; sw_a = 0;
      req_b = 0; we_req_b = 0; addr_b = 0; wdata_b = 0; sw_b = 0;
      ref_rdata = 16'h0000; ref_hex = 16'h0000;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      // reset then idle
      chk("reset_rdata", rdata_a, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("idle_oe_n", sram_oe_n_a, 1'b1);
         chk("idle_we_n", sram_we_n_a, 1'b1);
         chk("idle_hex", hex_out_a, 16'h0000);
         chk("idle_done", done_a, 1'b0);
         chk("idle_busy", busy_a, 1'b0);
      end

      // directed SRAM write then read
      access_a(1'b1, 16'h0010, 16'hBEEF, lat, oe_lo, we_lo, hold_err, rd);
      chk("wr_latency", lat, WS_A + 2);
      chk("wr_we_low_cycles", we_lo, WS_A + 1);
      chk("wr_oe_low_cycles", oe_lo, 0);
      chk("wr_addr_data_hold", hold_err, 0);
      ref_mem[16] = 16'hBEEF; pool.push_back(16);

      access_a(1'b0, 16'h0010, 16'h0000, lat, oe_lo, we_lo, hold_err, rd);
      chk("rd_latency", lat, WS_A + 2);
      chk("rd_oe_low_cycles", oe_lo, WS_A + 1);
      chk("rd_we_low_cycles", we_lo, 0);
      chk("rd_data", rd, 16'hBEEF);
      ref_rdata = 16'hBEEF;

      // I/O read of switches, I/O write of hex
      sw_a = 10'h2A5;
      repeat (3) @(negedge Clk);
      access_a(1'b0, IO_A, 16'h0000, lat, oe_lo, we_lo, hold_err, rd);
      chk("io_rd_latency", lat, 1);
      chk("io_rd_strobes", oe_lo + we_lo, 0);
      chk("io_rd_data", rd, 16'h02A5);
      ref_rdata = 16'h02A5;
      access_a(1'b1, IO_A, 16'h1234, lat, oe_lo, we_lo, hold_err, rd);
      chk("io_wr_latency", lat, 1);
      chk("io_wr_strobes", oe_lo + we_lo, 0);
      chk("io_wr_hex", hex_out_a, 16'h1234);
      chk("io_wr_rdata_held", rd, ref_rdata);
      ref_hex = 16'h1234;

      // randomized mix against the reference model
      for (int it = 0; it < 40; it++) begin
         sw_a = 10'($urandom);
         repeat (3) @(negedge Clk);
         kind = $urandom_range(0, 3);
         if (kind == 3 && pool.size() == 0) kind = 2;
         d = 16'($urandom);
         case (kind)
            0: begin
               access_a(1'b0, IO_A, d, lat, oe_lo, we_lo, hold_err, rd);
               ref_rdata = {6'b0, sw_a};
               chk("rnd_io_rd_latency", lat, 1);
               chk("rnd_io_rd_strobes", oe_lo + we_lo, 0);
               chk("rnd_io_rd_data", rd, ref_rdata);
            end
            1: begin
               access_a(1'b1, IO_A, d, lat, oe_lo, we_lo, hold_err, rd);
               ref_hex = d;
               chk("rnd_io_wr_latency", lat, 1);
               chk("rnd_io_wr_strobes", oe_lo + we_lo, 0);
               chk("rnd_io_wr_hex", hex_out_a, ref_hex);
               chk("rnd_io_wr_rdata_held", rd, ref_rdata);
            end
            2: begin
               a = 16'($urandom_range(0, 200));
               access_a(1'b1, a, d, lat, oe_lo, we_lo, hold_err, rd);
               ref_mem[a[7:0]] = d;
               pool.push_back(int'(a));
               chk("rnd_wr_latency", lat, WS_A + 2);
               chk("rnd_wr_we_low", we_lo, WS_A + 1);
               chk("rnd_wr_oe_low", oe_lo, 0);
               chk("rnd_wr_hold", hold_err, 0);
               chk("rnd_wr_rdata_held", rd, ref_rdata);
            end
            default: begin
               a = 16'(pool[$urandom_range(0, pool.size() - 1)]);
               access_a(1'b0, a, d, lat, oe_lo, we_lo, hold_err, rd);
               ref_rdata = ref_mem[a[7:0]];
               chk("rnd_rd_latency", lat, WS_A + 2);
               chk("rnd_rd_oe_low", oe_lo, WS_A + 1);
               chk("rnd_rd_we_low", we_lo, 0);
               chk("rnd_rd_hold", hold_err, 0);
               chk("rnd_rd_data", rd, ref_rdata);
            end
         endcase
      end

      // zero wait states, req held high for 10 cycles
      exp_acc = 0;
      for (int e = 1; e <= 10; e += WS_B + 3) exp_acc++;
      n_done = 0; n_acc = 0; last_done = 0; gap_err = 0;
      @(negedge Clk);
      req_b = 1'b1; we_req_b = 1'b0; addr_b = 16'h0040;
      for (int n = 1; n <= 16; n++) begin
         @(negedge Clk);
         if (n == 10) req_b = 1'b0;
         if (!sram_oe_n_b) n_acc++;
         if (done_b) begin
            n_done++;
            if (rdata_b !== 16'hFFBF) gap_err++;
            if (last_done != 0 && n - last_done != WS_B + 3) gap_err++;
            last_done = n;
         end
      end
      chk("b2b_done_count", n_done, exp_acc);
      chk("b2b_access_cycles", n_acc, exp_acc);
      chk("b2b_spacing_data", gap_err, 0);
      chk("b2b_no_write", sram_we_n_b, 1'b1);
      chk("b2b_wdata", sram_wdata_b, 16'h0000);
      chk("b2b_hex", hex_out_b, 16'h0000);

      // reset in ACCESS cycle 2 of a write
      @(negedge Clk);
      req_a = 1'b1; we_req_a = 1'b1; addr_a = 16'h00F0; wdata_a = 16'h5A5A;
      @(negedge Clk);
      req_a = 1'b0;
      @(negedge Clk);
      chk("abort_we_low_before", sram_we_n_a, 1'b0);
      Reset = 1'b1;
      #1;
      chk("abort_we_n", sram_we_n_a, 1'b1);
      chk("abort_oe_n", sram_oe_n_a, 1'b1);
      chk("abort_busy", busy_a, 1'b0);
      chk("abort_hex", hex_out_a, 16'h0000);
      @(negedge Clk);
      Reset = 1'b0;
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (done_a) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      chk("abort_rdata", rdata_a, 16'h0000);
      chk("abort_idle", busy_a, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
